// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_countdown_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Clamp a raw nibble to a legal BCD digit.
    function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle between the countdown timer and its controller.
interface bcd_countdown_if
    import bcd_countdown_pkg::*;
#(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned CW = DIGIT_W * DIGITS;

    logic          load;
    logic [CW-1:0] load_value;
    logic          start;
    logic          pause;
    logic [CW-1:0] count;
    logic          running;
    logic          done;

    modport master (
        output load, load_value, start, pause,
        input  count, running, done
    );

    modport slave (
        input  load, load_value, start, pause,
        output count, running, done
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement with ripple borrow.
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Prescaled multi-digit BCD countdown timer with start/pause/resume control.
// Optional feature macro: BCD_COUNTDOWN_AUTO_RELOAD_EN (reload on terminal count).
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned PRESCALE = 4
) (
    input logic            clk,
    input logic            rst,
    bcd_countdown_if.slave bus
);

    localparam int unsigned CW = DIGIT_W * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    state_e        state;
    logic [PW-1:0] psc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] dec_value;
    logic [CW-1:0] load_sat;
    logic [DIGITS:0] borrow;
    logic          running_q;
    logic          done_q;
    logic          tick;
    logic          term;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [CW-1:0] reload_q;
`endif

    // Borrow chain from the least significant digit upward.
    assign borrow[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit      (count_q[i*DIGIT_W +: DIGIT_W]),
            .borrow_in  (borrow[i]),
            .digit_next (dec_value[i*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[i+1])
        );
        assign load_sat[i*DIGIT_W +: DIGIT_W] = bcd_sat(bus.load_value[i*DIGIT_W +: DIGIT_W]);
    end

    assign tick = (state == RUN) && (psc == P_LAST);
    // A borrow out of the top digit would mean underflow; treat it as terminal too.
    assign term = borrow[DIGITS] || (dec_value == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count_q   <= '0;
            psc       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                count_q   <= load_sat;
                psc       <= '0;
                state     <= IDLE;
                running_q <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                reload_q  <= load_sat;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && (count_q != '0)) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state     <= PAUSED;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            psc <= '0;
                            if (term) begin
                                done_q <= 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                                if (reload_q != '0) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q   <= '0;
                                    state     <= DONE;
                                    running_q <= 1'b0;
                                end
`else
                                count_q   <= '0;
                                state     <= DONE;
                                running_q <= 1'b0;
`endif
                            end else begin
                                count_q <= dec_value;
                            end
                        end else begin
                            psc <= psc + PW'(1);
                        end
                    end
                    PAUSED: begin
                        if (bus.start && !bus.pause) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    DONE: begin
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule
